synch_bin_counter: RTL and testbench
====================================

Name: synch_bin_counter

Overview:
- Parameterisable synchronous up-counter: `counter` increments by one on each rising clock edge while `ena` is high.
- The count wraps modulo 2^Nbits.
- General-purpose timebase/sequence counter for the FPGA designs; runs at the 50 MHz system clock (20 ns period).
- Also provides a single-cycle terminal-count flag for cascading.

Parameters:
- Nbits, 4, counter width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high; sampled on the rising edge of clk.
- ena  input  1  count enable, active-high.
- counter  output  Nbits  current count value, driven directly from a register.
- max_tick  output  1  high whenever counter equals 2^Nbits-1 and ena is high (combinational, for cascading).

Behaviour:
- Single clock domain (clk).
- Reset is synchronous and active-high. No asynchronous reset path exists.
- Register update at each rising edge of clk, in priority order:
  - rst=1 -> counter <= 0, regardless of ena.
  - rst=0, ena=1 -> counter <= counter + 1, modulo 2^Nbits.
  - rst=0, ena=0 -> counter holds its value.
- Reset value: counter = 0. max_tick = 0 while counter = 0 (for Nbits >= 1 where max > 0).
- Wrap-around:
  - The count after 2^Nbits-1 is 0, with no sticky overflow state.
  - Nbits=4 sequence: 0,1,...,15,0,1,...
- Latency: counter reflects an enable sampled at edge k immediately after edge k (one-register latency).
- max_tick:
  - Combinational: (counter == {Nbits{1'b1}}) && ena && !rst.
  - Asserted for exactly one cycle per wrap under continuous enable.
  - A cascaded counter using max_tick as its ena advances on the same edge this counter wraps to 0.
- Simultaneous events: rst and ena both high -> reset wins; counter = 0 after the edge and max_tick = 0.
- Reset mid-count: rst asserted at any count value forces 0 on the next rising edge. Counting resumes from 0 on the first edge where rst=0 and ena=1.
- Before the first reset edge, counter is undefined in simulation (X). An FPGA initial value of 0 is permitted but not relied upon.
- Adder arithmetic is Nbits wide; the carry-out is discarded. No saturation.
- Outputs are glitch-free registered values, except max_tick, which is combinational.

Test Plan:
- Reset: rst=1, ena=0 for 50 ns (≥2 rising edges) -> counter=0, max_tick=0.
- Count run: rst=0, ena=1 for 200 ns (10 edges) from 0 -> counter steps 1..10 on successive edges, with no skipped or repeated values.
- Wrap: continue ena=1 for another 600 ns (30 edges) -> counter passes 15 then 0 and continues. max_tick is high only in the cycle counter=15, and this repeats every 16 edges.
- Hold: deassert ena at counter=7 for 5 edges -> counter stays 7. Reassert ena -> next edge gives 8.
- Reset priority/mid-count: at counter=12 drive rst=1 with ena=1 for one edge -> counter=0 and max_tick=0. Release rst -> next edge gives 1.
- Width: instantiate with Nbits=3 and ena=1 from reset -> sequence 0..7,0, with max_tick high at 7.

Source files
------------

// File: rtl/synch_bin_counter.sv
// Synchronous modulo-2^Nbits up-counter with a combinational terminal-count flag.
// max_tick lets the next counter in a chain use it directly as its enable.
module synch_bin_counter #(
  parameter int Nbits = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  output logic [Nbits-1:0] counter,
  output logic             max_tick
);

  localparam logic [Nbits-1:0] COUNT_MAX = {Nbits{1'b1}};
  localparam logic [Nbits-1:0] COUNT_ONE = Nbits'(1);

  // The sum is Nbits wide, so the count wraps to zero with no carry kept.
  always_ff @(posedge clk) begin
    if (rst)
      counter <= '0;
    else if (ena)
      counter <= counter + COUNT_ONE;
  end

  // Gated by !rst so the downstream stage stays put when this stage is reset.
  always_comb begin
    max_tick = (counter == COUNT_MAX) && ena && !rst;
  end

endmodule

// File: tb/tb_synch_bin_counter.sv
// Scoreboard bench for synch_bin_counter: Nbits=4 and Nbits=3 instances driven
// from the same rst/ena, each checked against its own reference count.
module tb_synch_bin_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [3:0] cnt4;
  logic       tick4;
  logic [2:0] cnt3;
  logic       tick3;

  always #10 clk = ~clk;

  synch_bin_counter #(.Nbits(4)) dut4 (
    .clk(clk), .rst(rst), .ena(ena), .counter(cnt4), .max_tick(tick4)
  );

  synch_bin_counter #(.Nbits(3)) dut3 (
    .clk(clk), .rst(rst), .ena(ena), .counter(cnt3), .max_tick(tick3)
  );

  typedef struct packed {
    logic [3:0] c4;
    logic [2:0] c3;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m4;
  logic [2:0] m3;
  int         checks = 0;
  int         passed = 0;
  int         ticks4 = 0;
  int         ticks3 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp)
      passed++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle: drive at negedge, check the flag, predict, check after posedge.
  task automatic step(input logic r, input logic e);
    exp_t x;
    @(negedge clk);
    rst = r;
    ena = e;
    #1;
    check("max_tick4", {31'd0, tick4}, {31'd0, (m4 == 4'hF) && e && !r});
    check("max_tick3", {31'd0, tick3}, {31'd0, (m3 == 3'h7) && e && !r});
    if (tick4 === 1'b1) ticks4++;
    if (tick3 === 1'b1) ticks3++;
    if (r) begin
      m4 = 4'd0;
      m3 = 3'd0;
    end else if (e) begin
      m4 = 4'((int'(m4) + 1) % 16);
      m3 = 3'((int'(m3) + 1) % 8);
    end
    sb.push_back('{c4: m4, c3: m3});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      check("counter4", {28'd0, cnt4}, {28'd0, x.c4});
      check("counter3", {29'd0, cnt3}, {29'd0, x.c3});
    end
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b0;
    m4  = 'x;
    m3  = 'x;

    // Reset with enable low.
    repeat (3) step(1'b1, 1'b0);
    check("reset_cnt4", {28'd0, cnt4}, 32'd0);
    check("reset_tick4", {31'd0, tick4}, 32'd0);
    check("reset_cnt3", {29'd0, cnt3}, 32'd0);

    // Narrow instance: 0..7 then wrap, tick at 7 during the eighth cycle.
    ticks3 = 0;
    repeat (7) step(1'b0, 1'b1);
    check("w3_at7", {29'd0, cnt3}, 32'd7);
    step(1'b0, 1'b1);
    check("w3_wrap0", {29'd0, cnt3}, 32'd0);
    check("w3_ticks", ticks3, 32'd1);

    // Restart from reset and run 10 edges.
    step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b1);
    check("count_run", {28'd0, cnt4}, 32'd10);

    // 30 more edges: passes 15 at 15 and 31 -> two ticks, ends at 40 mod 16.
    ticks4 = 0;
    repeat (30) step(1'b0, 1'b1);
    check("wrap_ticks", ticks4, 32'd2);
    check("wrap_cnt", {28'd0, cnt4}, 32'd8);

    // Hold at 7.
    repeat (15) step(1'b0, 1'b1);
    check("hold_pre", {28'd0, cnt4}, 32'd7);
    repeat (5) step(1'b0, 1'b0);
    check("hold_cnt", {28'd0, cnt4}, 32'd7);
    step(1'b0, 1'b1);
    check("hold_resume", {28'd0, cnt4}, 32'd8);

    // Reset priority at 12 with ena high.
    repeat (4) step(1'b0, 1'b1);
    check("mid_pre", {28'd0, cnt4}, 32'd12);
    step(1'b1, 1'b1);
    check("mid_rst_cnt", {28'd0, cnt4}, 32'd0);
    check("mid_rst_tick", {31'd0, tick4}, 32'd0);
    step(1'b0, 1'b1);
    check("mid_resume", {28'd0, cnt4}, 32'd1);

    // At terminal count, rst with ena must suppress max_tick.
    repeat (14) step(1'b0, 1'b1);
    check("term_pre", {28'd0, cnt4}, 32'd15);
    @(negedge clk);
    rst = 1'b1;
    ena = 1'b1;
    #1;
    check("term_rst_tick", {31'd0, tick4}, 32'd0);
    rst = 1'b0;
    #1;
    check("term_tick", {31'd0, tick4}, 32'd1);
    step(1'b1, 1'b1);
    check("term_rst_cnt", {28'd0, cnt4}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
